// File: rtl/library_load_if.sv
// Request, memory-read and point-stream signals of library_load.
// slave: the loader. master: the controller/memory/consumer side.
interface library_load_if;
    logic        i_start;
    logic [4:0]  i_slot;
    logic [10:0] i_len;
    logic        o_rd;
    logic [19:0] o_addr;
    logic [9:0]  i_rdata;
    logic [4:0]  o_x;
    logic [4:0]  o_y;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport slave (
        input  i_start, i_slot, i_len, i_rdata, i_ready,
        output o_rd, o_addr, o_x, o_y, o_valid, o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_slot, i_len, i_rdata, i_ready,
        input  o_rd, o_addr, o_x, o_y, o_valid, o_busy, o_done, o_err
    );
endinterface

// File: rtl/library_load.sv
// Reads back one slot of points from a fixed-latency memory and streams
// them out in index order through a small credit-protected FIFO.
// Ports: i_clk, i_rst (sync, active-high); bus (library_load_if.slave):
//   i_start/i_slot/i_len request, o_rd/o_addr/i_rdata memory read,
//   o_x/o_y/o_valid/i_ready point stream, o_busy/o_done/o_err status.
// Option LIBRARY_LOAD_ABORT_EN adds i_abort (stop, flush, wait RD_LAT).
module library_load #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
`ifdef LIBRARY_LOAD_ABORT_EN
    input  logic          i_abort,
`endif
    library_load_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0]  MAX_SLOT  = 5'd25;
    localparam logic [19:0] IDLE_ADDR = 20'h06C00;
    localparam logic [CW:0] DEPTH_W   = (CW + 1)'(FIFO_DEPTH);

`ifdef LIBRARY_LOAD_ABORT_EN
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [4:0]        slot_q;
    logic [10:0]       len_q;
    logic [10:0]       idx_q;
    logic [RD_LAT-1:0] pipe;
    logic [9:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW:0]       used;
    logic [9:0]        head;
    logic              done_q;
    logic              err_q;
    logic              abort;
    logic              start;
    logic              start_ok;
    logic              rd;
    logic              ret;
    logic              push;
    logic              pop;
    logic              last_idx;
    logic              last_pop;

    // Reads in flight: one bit per outstanding cycle of memory latency.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

`ifdef LIBRARY_LOAD_ABORT_EN
    assign abort = i_abort && (state_q == READ || state_q == DRAIN);
`else
    assign abort = 1'b0;
`endif

    assign start    = bus.i_start && (state_q == IDLE);
    assign start_ok = start && (bus.i_slot <= MAX_SLOT) && (bus.i_len != 11'd0);
    // Credit rule: never issue more reads than the FIFO can absorb.
    assign used     = {1'b0, inflight} + {1'b0, count};
    assign rd       = (state_q == READ) && !abort && (used < DEPTH_W);
    assign last_idx = (idx_q == len_q - 11'd1);
    assign ret      = pipe[RD_LAT-1];
    assign push     = ret && !abort;
    assign pop      = (count != '0) && bus.i_ready;
    assign head     = mem[rptr];
    // Last point leaves when nothing else is buffered or still returning.
    assign last_pop = (state_q == DRAIN) && pop && !abort
                   && (count == CW'(1)) && (inflight == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef LIBRARY_LOAD_ABORT_EN
    logic [1:0] flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || abort) begin
            flush_cnt <= 2'd0;
        end else if (state_q == FLUSH) begin
            flush_cnt <= flush_cnt + 2'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = READ;
            end
            READ: begin
                if (rd && last_idx) state_d = DRAIN;
`ifdef LIBRARY_LOAD_ABORT_EN
                if (abort) state_d = FLUSH;
`endif
            end
            DRAIN: begin
                if (last_pop) state_d = IDLE;
`ifdef LIBRARY_LOAD_ABORT_EN
                if (abort) state_d = FLUSH;
`endif
            end
`ifdef LIBRARY_LOAD_ABORT_EN
            FLUSH: begin
                if (flush_cnt == 2'(RD_LAT - 1)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            pipe   <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (start) begin
                if (bus.i_slot > MAX_SLOT) begin
                    err_q <= 1'b1;
                end else if (bus.i_len == 11'd0) begin
                    done_q <= 1'b1;
                end else begin
                    slot_q <= bus.i_slot;
                    len_q  <= bus.i_len;
                    idx_q  <= '0;
                end
            end
            if (rd) idx_q <= idx_q + 11'd1;
            // Abort forgets every outstanding read so late data is dropped.
            if (abort) begin
                pipe <= '0;
            end else begin
                pipe[0] <= rd;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            if (abort) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= bus.i_rdata;
    end

    assign bus.o_rd    = rd;
    assign bus.o_addr  = rd ? {4'b0, slot_q, idx_q} : IDLE_ADDR;
    assign bus.o_valid = (count != '0);
    assign bus.o_x     = bus.o_valid ? head[9:5] : 5'd0;
    assign bus.o_y     = bus.o_valid ? head[4:0] : 5'd0;
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_done  = done_q || last_pop;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_library_load.sv
// Testbench for library_load: memory model with fixed latency, point
// scoreboard, table of request vectors plus hold/reset/abort sequences.
module tb_library_load;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic i_clk;
    logic i_rst;
`ifdef LIBRARY_LOAD_ABORT_EN
    logic i_abort;
`endif

    library_load_if bus ();

    library_load #(
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
`ifdef LIBRARY_LOAD_ABORT_EN
        .i_abort (i_abort),
`endif
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  slot;
        logic [10:0] len;
        int          mode;
        int          exp_reads;
        int          exp_pts;
        int          exp_done;
        int          exp_err;
        logic [19:0] exp_last;
        int          exp_busy;
    } vec_t;

    int n_cmp;
    int n_bad;

    logic       q_v [0:RD_LAT];
    logic [9:0] q_d [0:RD_LAT];

    logic [4:0]  cur_slot;
    int          cur_len;
    int          nreads;
    int          npts;
    int          ndone;
    int          nerr;
    int          occ;
    int          max_occ;
    int          busy_seen;
    logic [19:0] last_addr;
    logic        hold_valid;
    logic [9:0]  held;

    logic        obs_rd;
    logic [19:0] obs_addr;
    logic        obs_valid;
    logic [9:0]  obs_xy;
    logic        obs_busy;
    logic        obs_done;
    logic        obs_err;

    function automatic logic [9:0] word(input logic [19:0] a);
        return {a[4:0], a[15:11] ^ a[4:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic clear_sb(input logic [4:0] s, input int l);
        cur_slot   = s;
        cur_len    = l;
        nreads     = 0;
        npts       = 0;
        ndone      = 0;
        nerr       = 0;
        occ        = 0;
        max_occ    = 0;
        busy_seen  = 0;
        last_addr  = 20'h06C00;
        hold_valid = 1'b0;
    endtask

    // One cycle: inputs already set; observe, drive memory data, advance.
    task automatic cyc();
        logic pop;
        logic ret;
        #1;
        obs_rd    = bus.o_rd;
        obs_addr  = bus.o_addr;
        obs_valid = bus.o_valid;
        obs_xy    = {bus.o_x, bus.o_y};
        obs_busy  = bus.o_busy;
        obs_done  = bus.o_done;
        obs_err   = bus.o_err;
        for (int k = RD_LAT; k > 0; k--) begin
            q_v[k] = q_v[k-1];
            q_d[k] = q_d[k-1];
        end
        q_v[0] = obs_rd;
        q_d[0] = word(obs_addr);
        bus.i_rdata = q_v[RD_LAT] ? q_d[RD_LAT] : 10'h2AA;
        ret = q_v[RD_LAT];
        pop = obs_valid && bus.i_ready;
        if (obs_rd) begin
            check("rd_addr", obs_addr, {4'b0, cur_slot, 11'(nreads)});
            nreads++;
            last_addr = obs_addr;
        end else begin
            check("idle_addr", obs_addr, 20'h06C00);
        end
        if (!obs_valid) check("empty_xy", obs_xy, 10'd0);
        if (hold_valid) check("stable_xy", obs_xy, held);
        hold_valid = obs_valid && !bus.i_ready;
        held = obs_xy;
        if (pop) begin
            check("point", obs_xy, word({4'b0, cur_slot, 11'(npts)}));
            npts++;
        end
        if (obs_busy) busy_seen = 1;
        if (obs_err) nerr++;
        if (obs_done) begin
            ndone++;
            if (cur_len != 0) check("done_at_last", npts, cur_len);
        end
        occ = occ + int'(ret) - int'(pop);
        if (occ > max_occ) max_occ = occ;
        @(negedge i_clk);
    endtask

    task automatic set_ready(input int mode, input int k);
        case (mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = 1'($urandom_range(0, 1));
            default: bus.i_ready = 1'(k & 1);
        endcase
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int k;
        clear_sb(v.slot, int'(v.len));
        bus.i_slot  = v.slot;
        bus.i_len   = v.len;
        bus.i_start = 1'b1;
        set_ready(v.mode, 0);
        cyc();
        bus.i_start = 1'b0;
        bus.i_slot  = 5'd0;
        bus.i_len   = 11'd0;
        k = 1;
        while (ndone + nerr == 0 && k < 20000) begin
            set_ready(v.mode, k);
            cyc();
            k++;
        end
        check($sformatf("v%0d_no_timeout", id), 32'(k < 20000), 1);
        repeat (RD_LAT + 2) begin
            set_ready(v.mode, k);
            cyc();
            k++;
        end
        check($sformatf("v%0d_reads", id), nreads, v.exp_reads);
        check($sformatf("v%0d_points", id), npts, v.exp_pts);
        check($sformatf("v%0d_done", id), ndone, v.exp_done);
        check($sformatf("v%0d_err", id), nerr, v.exp_err);
        check($sformatf("v%0d_last_addr", id), last_addr, v.exp_last);
        check($sformatf("v%0d_busy_seen", id), busy_seen, v.exp_busy);
        check($sformatf("v%0d_idle_after", id), obs_busy, 0);
        check($sformatf("v%0d_occ_bound", id), 32'(max_occ <= DEPTH), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, bus.o_rd, 0);
        check({tag, "_addr"}, bus.o_addr, 20'h06C00);
        check({tag, "_valid"}, bus.o_valid, 0);
        check({tag, "_xy"}, {bus.o_x, bus.o_y}, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_done"}, bus.o_done, 0);
        check({tag, "_err"}, bus.o_err, 0);
    endtask

    vec_t vt [7];
    vec_t vr;

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        vt[0] = '{5'd3,  11'd5,    0, 5,    5,    1, 0, 20'h01804, 1};
        vt[1] = '{5'd26, 11'd4,    0, 0,    0,    0, 1, 20'h06C00, 0};
        vt[2] = '{5'd0,  11'd0,    0, 0,    0,    1, 0, 20'h06C00, 0};
        vt[3] = '{5'd31, 11'd9,    0, 0,    0,    0, 1, 20'h06C00, 0};
        vt[4] = '{5'd1,  11'd1,    2, 1,    1,    1, 0, 20'h00800, 1};
        vt[5] = '{5'd7,  11'd3,    2, 3,    3,    1, 0, 20'h03802, 1};
        vt[6] = '{5'd25, 11'd2047, 1, 2047, 2047, 1, 0, 20'h0CFFE, 1};
        vr    = '{5'd6,  11'd4,    0, 4,    4,    1, 0, 20'h03003, 1};

        for (int i = 0; i <= RD_LAT; i++) begin
            q_v[i] = 1'b0;
            q_d[i] = 10'd0;
        end
        i_rst       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_slot  = 5'd0;
        bus.i_len   = 11'd0;
        bus.i_rdata = 10'd0;
        bus.i_ready = 1'b0;
`ifdef LIBRARY_LOAD_ABORT_EN
        i_abort = 1'b0;
`endif
        clear_sb(5'd0, 0);
        repeat (3) @(negedge i_clk);
        #1;
        check_reset_outputs("rst");
        i_rst = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i], i);
        end

        // Consumer stalled: credits stop reads at the FIFO depth.
        clear_sb(5'd2, 8);
        bus.i_slot  = 5'd2;
        bus.i_len   = 11'd8;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b0;
        cyc();
        bus.i_start = 1'b0;
        repeat (20) cyc();
        check("hold_reads", nreads, 4);
        check("hold_valid", obs_valid, 1);
        check("hold_head", obs_xy, word({4'b0, 5'd2, 11'd0}));
        bus.i_ready = 1'b1;
        k = 0;
        while (ndone == 0 && k < 100) begin
            cyc();
            k++;
        end
        repeat (3) cyc();
        check("hold_reads_all", nreads, 8);
        check("hold_points", npts, 8);
        check("hold_done", ndone, 1);

        // Reset in the middle of a read burst.
        clear_sb(5'd5, 20);
        bus.i_slot  = 5'd5;
        bus.i_len   = 11'd20;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        repeat (6) cyc();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        hold_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cyc();
        cyc();
        run_txn(vr, 7);

`ifdef LIBRARY_LOAD_ABORT_EN
        // Abort after three reads: stop, flush, idle after the latency.
        clear_sb(5'd4, 10);
        bus.i_slot  = 5'd4;
        bus.i_len   = 11'd10;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b0;
        cyc();
        bus.i_start = 1'b0;
        k = 0;
        while (nreads < 3 && k < 20) begin
            cyc();
            k++;
        end
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        hold_valid = 1'b0;
        check("abort_rd", obs_rd, 0);
        check("abort_reads", nreads, 3);
        cyc();
        check("abort_valid", obs_valid, 0);
        check("abort_busy", obs_busy, 1);
        repeat (RD_LAT - 1) cyc();
        check("abort_flush_busy", obs_busy, 1);
        check("abort_flush_valid", obs_valid, 0);
        cyc();
        check("abort_idle", obs_busy, 0);
        check("abort_idle_valid", obs_valid, 0);
        repeat (3) cyc();
        check("abort_no_done", ndone, 0);
        check("abort_no_more_reads", nreads, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
